vga_sync_monitor: RTL
=====================

Name: vga_sync_monitor

Overview:
- Receive-side checker for the 640x480 VGA timing produced on the board (800 clocks/line, 521 lines/frame, active-low hsync 96 clocks, vsync 2 lines).
- Samples hsync/vsync/RGB in the pixel clock domain and reconstructs column/row position.
- Checks every line and frame against nominal timing, reports lock, and captures the pixel at a programmable probe coordinate.
- Used for loopback self-test of the video output path and for bring-up on the baseboard.

Parameters:
- H_TOTAL, 800: clocks per line.
- V_TOTAL, 521: lines per frame.
- H_SYNC, 96: hsync low width in clocks.
- V_SYNC, 2: vsync low width in lines.
- LOCK_FRAMES, 2: consecutive clean frames required to assert locked (range 1..15).
- CW, 10: column and row counter width.

Ports:
- app_clk  in  1  pixel clock. Same clock as the video source.
- app_arst_n  in  1  asynchronous active-low reset.
- hsync_in  in  1  active-low horizontal sync.
- vsync_in  in  1  active-low vertical sync.
- red_in  in  3  pixel red.
- green_in  in  3  pixel green.
- blue_in  in  2  pixel blue.
- probe_x  in  CW  probe column. Quasi-static.
- probe_y  in  CW  probe row. Quasi-static.
- col  out  CW  reconstructed column of the current registered sample.
- row  out  CW  reconstructed row of the current registered sample.
- locked  out  1  timing lock.
- line_err  out  1  one-cycle pulse on a horizontal timing violation.
- frame_err  out  1  one-cycle pulse on a vertical timing violation.
- frame_done  out  1  one-cycle pulse on each vsync falling edge.
- probe_pixel  out  8  captured pixel {red, green, blue}.
- probe_valid  out  1  one-cycle pulse when probe_pixel updates.

Behaviour:
- **Reset and input registering**
  - Reset: all outputs and internal state are 0. The hs_q and vs_q input registers reset to 1 (idle).
  - Same clock domain, so there is no synchronizer. hsync_in, vsync_in and RGB are registered once into hs_q, vs_q and pix_q.
  - col, row and pix_q all describe the same sample.
- **Edge definitions**
  - h_fall = hs_q & ~hsync_in; h_rise = ~hs_q & hsync_in. Same form for v_fall and v_rise.
- **Column counter**
  - On h_fall: col <= 0.
  - Otherwise: col <= col+1, saturating at 2^CW-1.
  - Result: the first low hs_q sample has col = 0.
- **Row counter**
  - On h_fall & v_fall: row <= 0.
  - On h_fall without v_fall: row <= row+1, saturating at 2^CW-1.
- **Horizontal checks** (active only once h_seen is set; h_seen is set by the first h_fall after reset)
  - At h_fall, col != H_TOTAL-1 → line_err.
  - At h_rise, col != H_SYNC-1 → line_err.
  - col reaching 2^CW-1 → line_err, asserted once per saturation.
- **Vertical checks** (active only once v_seen is set; v_seen is set by the first v_fall)
  - v_fall or v_rise without a simultaneous h_fall → frame_err.
  - At v_fall, row != V_TOTAL-1 → frame_err.
  - At v_rise, row != V_SYNC-1 → frame_err.
  - Row saturation → frame_err.
- **Lock state machine** (states SEARCH, COUNT, LOCKED; 4-bit clean-frame counter good_cnt)
  - SEARCH: first v_fall → COUNT, good_cnt = 0.
  - COUNT:
    - At v_fall with no error since the previous v_fall: good_cnt++.
    - When good_cnt reaches LOCK_FRAMES: → LOCKED, locked = 1.
  - Any line_err or frame_err, in any state: → SEARCH, locked = 0, good_cnt = 0, h_seen and v_seen cleared.
  - An error coincident with v_fall wins; the v_fall is not counted.
- frame_done pulses on every v_fall once v_seen is set, independent of lock.
- **Probe capture**
  - When col == probe_x and row == probe_y: probe_pixel <= pix_q and probe_valid pulses on the next cycle.
  - Capture happens at most once per frame, whether or not locked.
  - The probe coordinate is in sync-relative clocks, not the active window. Any fixed pixel pipeline offset upstream is the integrator's responsibility.
- **Latency**
  - col, row and the error pulses are valid 1 cycle after the pin sample.
  - probe_valid is 2 cycles after the pin sample.

Decomposition:
- Package vga_timing_pkg holds:
  - constants H_TOTAL=800, V_TOTAL=521, H_SYNC=96, V_SYNC=2, CW=10;
  - the lock-state encoding (SEARCH=0, COUNT=1, LOCKED=2).
- The package is shared with the sync generator, so transmitter and monitor cannot diverge.
- One natural sub-module: sync_edge_det. It holds the registered input and produces fall/rise strobes, and is instantiated for hsync and for vsync.

Test Plan:
1. Connect the board sync generator directly, probe 0,0, run 3 frames → line_err/frame_err never pulse; locked rises at the 2nd clean v_fall after the first v_fall; frame_done every 416,800 clocks.
2. Locked stream with one line shortened to 799 clocks → line_err pulses at that h_fall; locked drops the next cycle; relock after 1 acquisition v_fall plus 2 clean frames.
3. hsync low width 95 instead of 96 on a single line → line_err at h_rise (col=94); frame_err stays 0.
4. Frame with 520 lines → frame_err at v_fall (row=519); the corrupted frame is not counted toward lock.
5. Probe_x=5, probe_y=3 with pixel at that position = 8'hA5 → probe_pixel=8'hA5 with one probe_valid pulse per frame; reset asserted mid-frame clears all outputs immediately, and the monitor resumes from SEARCH.
6. Hold hsync_in high indefinitely after lock → col saturates at 1023; a single line_err pulse; locked = 0; no further pulses.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480 VGA timing constants and lock-state encoding,
// shared by the sync generator and the receive-side monitor.
package vga_timing_pkg;
    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 521;
    localparam int H_SYNC = 96;
    localparam int V_SYNC = 2;
    localparam int CW = 10;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        COUNT = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/vga_sync_monitor_if.sv
// vga_sync_monitor_if: video pins, probe coordinate and monitor status bundle.
interface vga_sync_monitor_if;
    logic hsync_in;
    logic vsync_in;
    logic [2:0] red_in;
    logic [2:0] green_in;
    logic [1:0] blue_in;
    logic [vga_timing_pkg::CW-1:0] probe_x;
    logic [vga_timing_pkg::CW-1:0] probe_y;
    logic [vga_timing_pkg::CW-1:0] col;
    logic [vga_timing_pkg::CW-1:0] row;
    logic locked;
    logic line_err;
    logic frame_err;
    logic frame_done;
    logic [7:0] probe_pixel;
    logic probe_valid;

    modport master (
        output hsync_in, vsync_in, red_in, green_in, blue_in, probe_x, probe_y,
        input col, row, locked, line_err, frame_err, frame_done, probe_pixel, probe_valid
    );
    modport slave (
        input hsync_in, vsync_in, red_in, green_in, blue_in, probe_x, probe_y,
        output col, row, locked, line_err, frame_err, frame_done, probe_pixel, probe_valid
    );
endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det: registers an active-low sync pin (idle high) and flags its edges
// against the live pin, so the strobe lines up with the cycle the sample is taken.
module sync_edge_det (
    input  logic app_clk,
    input  logic app_arst_n,
    input  logic sync_in,
    output logic fall,
    output logic rise
);
    logic sync_q;

    always_ff @(posedge app_clk or negedge app_arst_n)
        if (!app_arst_n) sync_q <= 1'b1;
        else sync_q <= sync_in;

    assign fall = sync_q & ~sync_in;
    assign rise = ~sync_q & sync_in;
endmodule

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: reconstructs column/row from VGA syncs, checks line and frame
// timing, tracks lock and captures the pixel at a probe coordinate.
module vga_sync_monitor #(
    parameter int H_TOTAL = vga_timing_pkg::H_TOTAL,
    parameter int V_TOTAL = vga_timing_pkg::V_TOTAL,
    parameter int H_SYNC = vga_timing_pkg::H_SYNC,
    parameter int V_SYNC = vga_timing_pkg::V_SYNC,
    parameter int LOCK_FRAMES = 2
) (
    input logic app_clk,
    input logic app_arst_n,
    vga_sync_monitor_if.slave vid
);
    import vga_timing_pkg::*;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] HS_LAST = CW'(H_SYNC - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] VS_LAST = CW'(V_SYNC - 1);
    localparam logic [CW-1:0] PRE_SAT = CW'(2 ** CW - 2);
    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    logic h_fall, h_rise, v_fall, v_rise;
    logic h_err, v_err, probe_hit;
    logic h_seen, v_seen, v_fall_q, probe_done;
    logic [7:0] pix_q;
    logic [CW-1:0] col, row;
    logic [3:0] good_cnt;
    lock_state_t state;

    sync_edge_det u_hs (.app_clk(app_clk), .app_arst_n(app_arst_n), .sync_in(vid.hsync_in), .fall(h_fall), .rise(h_rise));
    sync_edge_det u_vs (.app_clk(app_clk), .app_arst_n(app_arst_n), .sync_in(vid.vsync_in), .fall(v_fall), .rise(v_rise));

    // Saturation is flagged on the step into the top value, so it reports once.
    assign h_err = h_seen & (h_fall & (col != H_LAST) | h_rise & (col != HS_LAST) | ~h_fall & (col == PRE_SAT));
    assign v_err = v_seen & ((v_fall | v_rise) & ~h_fall | v_fall & (row != V_LAST) | v_rise & (row != VS_LAST)
                   | h_fall & ~v_fall & (row == PRE_SAT));
    assign probe_hit = ~probe_done & (col == vid.probe_x) & (row == vid.probe_y);
    assign vid.col = col;
    assign vid.row = row;

    always_ff @(posedge app_clk or negedge app_arst_n) begin
        if (!app_arst_n) begin
            pix_q <= '0;
            col <= '0;
            row <= '0;
            h_seen <= 1'b0;
            v_seen <= 1'b0;
            v_fall_q <= 1'b0;
            probe_done <= 1'b0;
            vid.line_err <= 1'b0;
            vid.frame_err <= 1'b0;
            vid.frame_done <= 1'b0;
            vid.probe_valid <= 1'b0;
            vid.probe_pixel <= '0;
        end else begin
            pix_q <= {vid.red_in, vid.green_in, vid.blue_in};
            col <= h_fall ? '0 : sat_inc(col);
            row <= h_fall ? (v_fall ? '0 : sat_inc(row)) : row;
            h_seen <= ~(h_err | v_err) & (h_seen | h_fall);
            v_seen <= ~(h_err | v_err) & (v_seen | v_fall);
            v_fall_q <= v_fall;
            probe_done <= ~v_fall & (probe_done | probe_hit);
            vid.line_err <= h_err;
            vid.frame_err <= v_err;
            vid.frame_done <= v_fall & v_seen;
            vid.probe_valid <= probe_hit;
            vid.probe_pixel <= probe_hit ? pix_q : vid.probe_pixel;
        end
    end

    // Lock follows the registered pulses, so an error aligned with v_fall wins.
    always_ff @(posedge app_clk or negedge app_arst_n) begin
        if (!app_arst_n) begin
            state <= SEARCH;
            good_cnt <= '0;
            vid.locked <= 1'b0;
        end else if (vid.line_err | vid.frame_err) begin
            state <= SEARCH;
            good_cnt <= '0;
            vid.locked <= 1'b0;
        end else if (v_fall_q) begin
            case (state)
                SEARCH: begin
                    state <= COUNT;
                    good_cnt <= '0;
                end
                COUNT: begin
                    good_cnt <= good_cnt + 4'd1;
                    if (good_cnt + 4'd1 == LOCK_N) begin
                        state <= LOCKED;
                        vid.locked <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
